// File: rtl/uart_pkg.sv
// Shared definitions for the UART arbiter: payload width, FSM states and
// the default WAIT timeout.
package uart_pkg;

  localparam int DATA_W                 = 7;
  localparam int TIMEOUT_CYCLES_DEFAULT = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SAVE = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

endpackage

// File: rtl/uart_rr_arbiter.sv
// Two-way round-robin pick. `last` is the requester served most recently;
// on a tie the other one wins, a lone request always wins.
module uart_rr_arbiter (
  input  logic req0,
  input  logic req1,
  input  logic last,
  output logic winner,
  output logic valid
);

  // Combinational winner selection
  always_comb begin
    valid  = req0 | req1;
    winner = 1'b0;
    if (req0 && req1) begin
      winner = ~last;
    end else if (req1) begin
      winner = 1'b1;
    end
  end

endmodule

// File: rtl/uart_arbiter.sv
// Shares one UART between two requesters. Each transaction walks
// IDLE -> SAVE -> WAIT -> RESP; WAIT is bounded by TIMEOUT_CYCLES.
module uart_arbiter
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [DATA_W-1:0] data0,
  input  logic [DATA_W-1:0] data1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [DATA_W-1:0] rx_data,
  output logic              timeout,
  output logic              busy,
  output logic [DATA_W-1:0] uart_data,
  output logic              uart_save,
  input  logic [DATA_W-1:0] uart_data_out,
  input  logic              uart_ready,
  input  logic              uart_error
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             last_reg;   // requester served most recently
  logic             owner_reg;  // requester owning the current transaction
  logic             arb_winner;
  logic             arb_valid;

  uart_rr_arbiter u_rr (
    .req0   (req0),
    .req1   (req1),
    .last   (last_reg),
    .winner (arb_winner),
    .valid  (arb_valid)
  );

  // Transaction FSM with all outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      last_reg  <= 1'b1;  // requester 0 wins the first tie
      owner_reg <= 1'b0;
      gnt0      <= 1'b0;
      gnt1      <= 1'b0;
      done0     <= 1'b0;
      done1     <= 1'b0;
      err0      <= 1'b0;
      err1      <= 1'b0;
      rx_data   <= '0;
      timeout   <= 1'b0;
      busy      <= 1'b0;
      uart_data <= '0;
      uart_save <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (arb_valid) begin
            state_reg <= SAVE;
            owner_reg <= arb_winner;
            last_reg  <= arb_winner;
            uart_data <= arb_winner ? data1 : data0;
            uart_save <= 1'b1;
            gnt0      <= ~arb_winner;
            gnt1      <= arb_winner;
            busy      <= 1'b1;
          end
        end
        SAVE: begin
          state_reg <= WAIT;
          uart_save <= 1'b0;
          cnt_reg   <= '0;
        end
        WAIT: begin
          // A ready arriving on the timeout cycle still counts as success
          if (uart_ready) begin
            state_reg <= RESP;
            rx_data   <= uart_data_out;
            timeout   <= 1'b0;
            done0     <= ~owner_reg;
            done1     <= owner_reg;
            err0      <= ~owner_reg & uart_error;
            err1      <= owner_reg & uart_error;
          end else if (cnt_reg == CNT_LAST) begin
            state_reg <= RESP;
            rx_data   <= '0;
            timeout   <= 1'b1;
            done0     <= ~owner_reg;
            done1     <= owner_reg;
            err0      <= ~owner_reg;
            err1      <= owner_reg;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        RESP: begin
          state_reg <= IDLE;
          done0     <= 1'b0;
          done1     <= 1'b0;
          err0      <= 1'b0;
          err1      <= 1'b0;
          gnt0      <= 1'b0;
          gnt1      <= 1'b0;
          busy      <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_arbiter.sv
// Directed bench for uart_arbiter, built with TIMEOUT_CYCLES=8.
module tb_uart_arbiter;

  logic       clk;
  logic       rst;
  logic       req0, req1;
  logic [6:0] data0, data1;
  logic       gnt0, gnt1, done0, done1, err0, err1;
  logic [6:0] rx_data;
  logic       timeout, busy;
  logic [6:0] uart_data;
  logic       uart_save;
  logic [6:0] uart_data_out;
  logic       uart_ready, uart_error;

  int vectors;
  int miscompares;

  uart_arbiter #(.TIMEOUT_CYCLES(8)) dut (
    .clk           (clk),
    .rst           (rst),
    .req0          (req0),
    .req1          (req1),
    .data0         (data0),
    .data1         (data1),
    .gnt0          (gnt0),
    .gnt1          (gnt1),
    .done0         (done0),
    .done1         (done1),
    .err0          (err0),
    .err1          (err1),
    .rx_data       (rx_data),
    .timeout       (timeout),
    .busy          (busy),
    .uart_data     (uart_data),
    .uart_save     (uart_save),
    .uart_data_out (uart_data_out),
    .uart_ready    (uart_ready),
    .uart_error    (uart_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 ns past it
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; req0 = 0; req1 = 0; data0 = 0; data1 = 0;
    uart_data_out = 0; uart_ready = 0; uart_error = 0;
    tick();
    tick();
    vectors++; if ({busy, gnt0, gnt1, uart_save, done0, done1, err0, err1, timeout} !== 9'b0) begin miscompares++; $display("FAIL reset_flags got %b exp 000000000", {busy, gnt0, gnt1, uart_save, done0, done1, err0, err1, timeout}); end
    vectors++; if ({rx_data, uart_data} !== 14'b0) begin miscompares++; $display("FAIL reset_data got rx=%h ud=%h exp 0", rx_data, uart_data); end
    rst = 1'b0;
    tick();
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_idle_busy got %b exp 0", busy); end
    $display("reset: done");
  endtask

  task automatic test_single;
    req0 = 1; data0 = 7'b1100110;
    tick();  // IDLE -> SAVE
    vectors++; if (uart_save !== 1'b1 || uart_data !== 7'b1100110) begin miscompares++; $display("FAIL single_save got save=%b data=%b exp 1/1100110", uart_save, uart_data); end
    vectors++; if (gnt0 !== 1'b1 || gnt1 !== 1'b0 || busy !== 1'b1) begin miscompares++; $display("FAIL single_gnt got g0=%b g1=%b busy=%b exp 1/0/1", gnt0, gnt1, busy); end
    tick();  // SAVE -> WAIT
    vectors++; if (uart_save !== 1'b0) begin miscompares++; $display("FAIL single_save_width got %b exp 0", uart_save); end
    tick();  // WAIT
    tick();  // WAIT
    uart_ready = 1; uart_data_out = 7'h2A; uart_error = 0;
    tick();  // WAIT -> RESP
    vectors++; if (done0 !== 1'b1 || err0 !== 1'b0 || done1 !== 1'b0 || timeout !== 1'b0) begin miscompares++; $display("FAIL single_done got d0=%b e0=%b d1=%b to=%b exp 1/0/0/0", done0, err0, done1, timeout); end
    vectors++; if (rx_data !== 7'h2A) begin miscompares++; $display("FAIL single_rx got %h exp 2a", rx_data); end
    uart_ready = 0; req0 = 0;
    tick();  // RESP -> IDLE
    vectors++; if (done0 !== 1'b0 || gnt0 !== 1'b0 || busy !== 1'b0 || rx_data !== 7'h2A) begin miscompares++; $display("FAIL single_idle got d0=%b g0=%b busy=%b rx=%h exp 0/0/0/2a", done0, gnt0, busy, rx_data); end
    $display("single: txn done");
  endtask

  task automatic test_back_to_back;
    do_reset();
    req0 = 1; req1 = 1; data0 = 7'h11; data1 = 7'h22;
    uart_ready = 1; uart_error = 0; uart_data_out = 7'h33;
    for (int i = 0; i < 4; i++) begin
      logic who;
      who = i[0];
      tick();  // SAVE
      vectors++; if (gnt0 !== ~who || gnt1 !== who) begin miscompares++; $display("FAIL b2b_gnt[%0d] got g0=%b g1=%b exp owner %0d", i, gnt0, gnt1, who); end
      vectors++; if (uart_data !== (who ? 7'h22 : 7'h11)) begin miscompares++; $display("FAIL b2b_data[%0d] got %h exp %h", i, uart_data, who ? 7'h22 : 7'h11); end
      tick();  // WAIT
      tick();  // RESP
      vectors++; if (done0 !== ~who || done1 !== who) begin miscompares++; $display("FAIL b2b_done[%0d] got d0=%b d1=%b exp owner %0d", i, done0, done1, who); end
      if (i == 3) begin req0 = 0; req1 = 0; uart_ready = 0; end
      tick();  // IDLE
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL b2b_idle[%0d] got busy=%b exp 0", i, busy); end
      $display("back_to_back: txn %0d owner %0d", i, who);
    end
  endtask

  task automatic test_uart_error;
    req1 = 1; data1 = 7'h55;
    tick();
    vectors++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || uart_data !== 7'h55) begin miscompares++; $display("FAIL uerr_gnt got g1=%b g0=%b ud=%h exp 1/0/55", gnt1, gnt0, uart_data); end
    tick();
    uart_ready = 1; uart_error = 1; uart_data_out = 7'h7F;
    tick();
    vectors++; if (done1 !== 1'b1 || err1 !== 1'b1 || done0 !== 1'b0 || err0 !== 1'b0 || timeout !== 1'b0) begin miscompares++; $display("FAIL uerr_done got d1=%b e1=%b d0=%b e0=%b to=%b exp 1/1/0/0/0", done1, err1, done0, err0, timeout); end
    vectors++; if (rx_data !== 7'h7F) begin miscompares++; $display("FAIL uerr_rx got %h exp 7f", rx_data); end
    uart_ready = 0; uart_error = 0; req1 = 0;
    tick();
    $display("uart_error: txn done");
  endtask

  task automatic test_timeout;
    int n;
    req0 = 1; data0 = 7'h05; uart_data_out = 7'h4C;
    tick();  // SAVE
    tick();  // first WAIT cycle
    n = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (done0 === 1'b1) begin n = i; break; end
    end
    vectors++; if (n !== 8) begin miscompares++; $display("FAIL timeout_latency got %0d wait cycles exp 8", n); end
    vectors++; if (err0 !== 1'b1 || timeout !== 1'b1 || rx_data !== 7'h00 || done1 !== 1'b0) begin miscompares++; $display("FAIL timeout_flags got e0=%b to=%b rx=%h d1=%b exp 1/1/00/0", err0, timeout, rx_data, done1); end
    req0 = 0;
    tick();
    vectors++; if (timeout !== 1'b1 || done0 !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL timeout_hold got to=%b d0=%b busy=%b exp 1/0/0", timeout, done0, busy); end
    $display("timeout: txn done after %0d wait cycles", n);
  endtask

  task automatic test_async_reset;
    int seen_done;
    // Reset while in SAVE: uart_save must drop without a clock edge
    req1 = 1; data1 = 7'h3C;
    tick();
    #2 rst = 1; req1 = 0;
    #1;
    vectors++; if (uart_save !== 1'b0 || busy !== 1'b0 || gnt1 !== 1'b0 || uart_data !== 7'h00) begin miscompares++; $display("FAIL areset_save got save=%b busy=%b g1=%b ud=%h exp 0/0/0/00", uart_save, busy, gnt1, uart_data); end
    #1 rst = 0;
    tick();
    // Reset mid-WAIT
    req0 = 1; data0 = 7'h1E;
    tick();
    tick();
    tick();
    #2 rst = 1; req0 = 0;
    #1;
    vectors++; if (busy !== 1'b0 || gnt0 !== 1'b0 || gnt1 !== 1'b0 || uart_save !== 1'b0) begin miscompares++; $display("FAIL areset_wait got busy=%b g0=%b g1=%b save=%b exp 0/0/0/0", busy, gnt0, gnt1, uart_save); end
    #1 rst = 0;
    uart_ready = 1;
    seen_done = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done0 === 1'b1 || done1 === 1'b1) seen_done++;
    end
    vectors++; if (seen_done !== 0) begin miscompares++; $display("FAIL areset_nodone got %0d done pulses exp 0", seen_done); end
    uart_ready = 0;
    $display("async_reset: aborted");
  endtask

  task automatic test_late_request;
    do_reset();
    req0 = 1; data0 = 7'h0F;
    tick();  // SAVE, owner 0
    req1 = 1; data1 = 7'h70; data0 = 7'h01;
    tick();  // WAIT
    vectors++; if (gnt1 !== 1'b0 || gnt0 !== 1'b1 || uart_data !== 7'h0F) begin miscompares++; $display("FAIL late_wait got g1=%b g0=%b ud=%h exp 0/1/0f", gnt1, gnt0, uart_data); end
    uart_ready = 1;
    tick();  // RESP
    vectors++; if (done0 !== 1'b1 || gnt1 !== 1'b0 || uart_data !== 7'h0F) begin miscompares++; $display("FAIL late_resp got d0=%b g1=%b ud=%h exp 1/0/0f", done0, gnt1, uart_data); end
    req0 = 0; uart_ready = 0;
    tick();  // IDLE
    vectors++; if (gnt1 !== 1'b0 || gnt0 !== 1'b0) begin miscompares++; $display("FAIL late_idle got g1=%b g0=%b exp 0/0", gnt1, gnt0); end
    tick();  // SAVE, owner 1
    vectors++; if (gnt1 !== 1'b1 || gnt0 !== 1'b0 || uart_data !== 7'h70 || uart_save !== 1'b1) begin miscompares++; $display("FAIL late_gnt1 got g1=%b g0=%b ud=%h save=%b exp 1/0/70/1", gnt1, gnt0, uart_data, uart_save); end
    tick();  // WAIT
    uart_ready = 1; uart_data_out = 7'h12;
    tick();  // RESP
    vectors++; if (done1 !== 1'b1 || rx_data !== 7'h12) begin miscompares++; $display("FAIL late_done1 got d1=%b rx=%h exp 1/12", done1, rx_data); end
    req1 = 0; uart_ready = 0;
    tick();
    $display("late_request: both served");
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_uart_error();
    test_timeout();
    test_async_reset();
    test_late_request();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_arbiter.md
UART_ARBITER -- requirements
Module: uart_arbiter

Interface
REQ-001 Parameter: TIMEOUT_CYCLES, default 255, maximum number of cycles spent in WAIT before the transaction is aborted.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: req0 / req1  input  1  requester 0/1 asks for one UART transaction; held high until the matching done.
REQ-005 Port: data0 / data1  input  7  requester 0/1 payload; must be stable while the matching req is high.
REQ-006 Port: gnt0 / gnt1  output  1  requester 0/1 owns the UART (SAVE through RESP).
REQ-007 Port: done0 / done1  output  1  one-cycle completion pulse to requester 0/1.
REQ-008 Port: err0 / err1  output  1  valid with done; UART error or timeout.
REQ-009 Port: rx_data  output  7  uart_data_out captured at completion.
REQ-010 Port: timeout  output  1  valid with done; set only when the transaction was aborted by timeout.
REQ-011 Port: busy  output  1  high in any state other than IDLE.
REQ-012 Port: uart_data  output  7  payload to the UART's data input.
REQ-013 Port: uart_save  output  1  one-cycle load strobe to the UART's save input.
REQ-014 Port: uart_data_out  input  7  UART returned data.
REQ-015 Port: uart_ready  input  1  UART transaction complete.
REQ-016 Port: uart_error  input  1  UART error flag; valid with uart_ready.

Function
REQ-017 FSM states SHALL be IDLE, SAVE, WAIT, RESP, all registered.
REQ-018 IDLE: if any req is high, latch the winner's data into uart_data and set the owner; go to SAVE on the next edge. Otherwise stay in IDLE.
REQ-019 Arbitration SHALL be two-way round-robin via a last-served pointer.
- If both requests are high, the requester not last served wins.
- A single request wins regardless of the pointer.
- The pointer updates on entry to SAVE.
REQ-020 SAVE: uart_save=1 for exactly one cycle; then go to WAIT with the cycle counter cleared.
- Latency: req seen in IDLE at edge k -> uart_save high during cycle k+1.
REQ-021 WAIT: uart_save=0 and the counter increments each cycle.
- uart_ready=1 -> go to RESP; capture rx_data=uart_data_out, err=uart_error, timeout=0.
REQ-022 WAIT timeout: if the counter reaches TIMEOUT_CYCLES-1 with uart_ready=0 -> go to RESP with rx_data=0, err=1, timeout=1.
- If uart_ready and the timeout coincide, ready wins.
REQ-023 RESP: done/err pulse for one cycle to the owner only; then go to IDLE.
- rx_data and timeout hold until the next RESP.
REQ-024 gntN SHALL be high from SAVE through RESP for the owner only; gnt0 and gnt1 are never high together.
REQ-025 uart_data SHALL stay constant from SAVE until the FSM leaves RESP.
- Changes on dataN after the grant are ignored.
REQ-026 A request raised or dropped while busy SHALL NOT affect the current transaction; it is evaluated only in IDLE.
REQ-027 A requester still holding req in the cycle after done SHALL be treated as a new request.
- Round-robin then favours the other requester if it is requesting.
REQ-028 Back-to-back throughput: minimum 4 cycles per transaction (IDLE, SAVE, WAIT for one cycle, RESP).

Reset
REQ-029 rst high SHALL immediately force the following, independent of clk:
- state=IDLE, counter=0, pointer=requester 1 (so requester 0 wins the first tie);
- all outputs 0: uart_save, gnt*, done*, err*, timeout, busy, rx_data, uart_data.
REQ-030 Reset mid-transaction SHALL abort it without a done pulse; uart_save deasserts asynchronously.

Structure
REQ-031 A shared package uart_pkg SHALL hold:
- DATA_W=7;
- the FSM state enum;
- the default TIMEOUT_CYCLES.
REQ-032 Round-robin selection SHALL be a sub-module uart_rr_arbiter (inputs req0, req1, last; outputs winner, valid).
- It is purely combinational.
- The pointer register lives in uart_arbiter.

Verification
REQ-033 Single request: req0=1, data0=7'b1100110; uart_ready=1 three cycles after save.
- Expect uart_save for exactly 1 cycle with uart_data=7'b1100110.
- Expect done0 pulse, err0=0, rx_data=uart_data_out.
REQ-034 Tie: req0=req1=1 from reset.
- Expect requester 0 served first, then requester 1.
- With both held, expect strict alternation 0,1,0,1.
REQ-035 UART error: uart_ready=1 with uart_error=1.
- Expect done1 with err1=1 and timeout=0.
REQ-036 Timeout: TIMEOUT_CYCLES=8 and uart_ready never rises.
- Expect done and err=1, timeout=1, rx_data=0 exactly 8 WAIT cycles after the save.
REQ-037 Async reset: rst pulsed mid-WAIT, between clock edges.
- Expect busy, gnt* and uart_save to go to 0 before the next edge, and no done pulse.
REQ-038 Late request: req1 rises during a requester-0 transaction.
- Expect gnt1 only after RESP, and uart_data unchanged while gnt0 is high.
